// File: rtl/shift_sequencer.sv
// Multi-cycle N-position shift controller: drives a combinational single-step
// shifter once per clock and folds its output back into an accumulator.
module shift_sequencer #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [CW-1:0] amount,
  input  logic [W-1:0]  din,
  output logic [1:0]    sh_shift,
  output logic [W-1:0]  sh_in,
  input  logic [W-1:0]  sh_out,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [1:0]    op_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_r  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= din;
            cnt  <= amount;
            op_r <= op;
            busy <= 1'b1;
            if (amount != '0) begin
              state <= SHIFT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          acc <= sh_out;
          cnt <= cnt - 1'b1;
          // Leaving at cnt==1 means cnt never reaches 0 here, so no wrap.
          if (cnt == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Shift select is decoded from state and the latched op only.
  assign sh_shift = (state == SHIFT) ? op_r : 2'b00;
  assign sh_in    = acc;
  assign result   = acc;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-step shifter.
module tb_shift_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [3:0]  amount;
  logic [15:0] din;
  logic [1:0]  sh_shift;
  logic [15:0] sh_in;
  logic [15:0] sh_out;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  shift_sequencer #(.W(16), .CW(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .din      (din),
    .sh_shift (sh_shift),
    .sh_in    (sh_in),
    .sh_out   (sh_out),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always_comb begin
    case (sh_shift)
      2'b01:   sh_out = {sh_in[14:0], 1'b0};
      2'b10:   sh_out = {1'b0, sh_in[15:1]};
      2'b11:   sh_out = {sh_in[15], sh_in[15:1]};
      default: sh_out = sh_in;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation, scrambles the inputs right after the accepting
  // edge, optionally re-pulses start at cycle 'poke', and stops #1 after the
  // edge where done is first seen high.
  task automatic run_op(input logic [1:0] o, input logic [3:0] a,
                        input logic [15:0] d, input int poke,
                        output int lat, output int shift_cycles,
                        output logic [1:0] seen, output int busy_low,
                        output logic timed_out);
    @(negedge clk);
    op = o; amount = a; din = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; amount = ~a; din = ~d;
    lat = 0; shift_cycles = 0; seen = 2'b00; busy_low = 0; timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (sh_shift !== 2'b00) shift_cycles++;
      seen = seen | sh_shift;
      if (busy !== 1'b1) busy_low++;
      if (lat == poke) begin
        start = 1'b1; din = 16'h1234; op = 2'b10; amount = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (lat >= 40) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 2'b00; amount = 4'd0; din = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
    checks++; if (sh_shift !== 2'b00) begin errors++; $display("FAIL reset_sh_shift got %b want 00", sh_shift); end
    checks++; if (sh_in !== 16'h0000) begin errors++; $display("FAIL reset_sh_in got %h want 0000", sh_in); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_shift_left();
    int lat, sc, bl; logic [1:0] seen; logic to;
    run_op(2'b01, 4'd4, 16'h0001, -1, lat, sc, seen, bl, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL left_timeout got %b want 0", to); end
    checks++; if (lat != 4) begin errors++; $display("FAIL left_latency got %0d want 4", lat); end
    checks++; if (sc != 4 || seen !== 2'b01) begin errors++; $display("FAIL left_sh_shift got cycles=%0d sel=%b want 4/01", sc, seen); end
    checks++; if (bl != 0) begin errors++; $display("FAIL left_busy got %0d low cycles want 0", bl); end
    checks++; if (result !== 16'h0010) begin errors++; $display("FAIL left_result got %h want 0010", result); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL left_after got done=%b busy=%b want 0/0", done, busy); end
    checks++; if (result !== 16'h0010) begin errors++; $display("FAIL left_result_hold got %h want 0010", result); end
  endtask

  task automatic test_right();
    int lat, sc, bl; logic [1:0] seen; logic to;
    run_op(2'b11, 4'd3, 16'h8000, -1, lat, sc, seen, bl, to);
    checks++; if (result !== 16'hF000 || lat != 3) begin errors++; $display("FAIL asr3 got %h lat=%0d want F000 lat=3", result, lat); end
    @(posedge clk); #1;
    run_op(2'b10, 4'd3, 16'h8000, -1, lat, sc, seen, bl, to);
    checks++; if (result !== 16'h1000 || lat != 3) begin errors++; $display("FAIL lsr3 got %h lat=%0d want 1000 lat=3", result, lat); end
    @(posedge clk); #1;
    run_op(2'b10, 4'd15, 16'h8000, -1, lat, sc, seen, bl, to);
    checks++; if (lat != 15 || to !== 1'b0) begin errors++; $display("FAIL lsr15_latency got %0d want 15", lat); end
    checks++; if (result !== 16'h0001) begin errors++; $display("FAIL lsr15_result got %h want 0001", result); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lsr15_after got done=%b busy=%b want 0/0", done, busy); end
    run_op(2'b00, 4'd5, 16'h5A3C, -1, lat, sc, seen, bl, to);
    checks++; if (result !== 16'h5A3C || lat != 5) begin errors++; $display("FAIL pass5 got %h lat=%0d want 5A3C lat=5", result, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_amount();
    int lat, sc, bl; logic [1:0] seen; logic to;
    run_op(2'b11, 4'd0, 16'hA5A5, -1, lat, sc, seen, bl, to);
    checks++; if (lat != 0) begin errors++; $display("FAIL zero_latency got %0d want done right after start edge", lat); end
    checks++; if (result !== 16'hA5A5) begin errors++; $display("FAIL zero_result got %h want A5A5", result); end
    checks++; if (sh_shift !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL zero_done_cycle got sel=%b busy=%b want 00/1", sh_shift, busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || sh_shift !== 2'b00) begin errors++; $display("FAIL zero_after got done=%b busy=%b sel=%b want 0/0/00", done, busy, sh_shift); end
  endtask

  task automatic test_ignore_start();
    int lat, sc, bl; logic [1:0] seen; logic to;
    run_op(2'b01, 4'd8, 16'h00FF, 3, lat, sc, seen, bl, to);
    checks++; if (lat != 8 || sc != 8) begin errors++; $display("FAIL ignore_latency got lat=%0d cycles=%0d want 8/8", lat, sc); end
    checks++; if (result !== 16'hFF00) begin errors++; $display("FAIL ignore_result got %h want FF00", result); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_after got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, sc, bl; logic [1:0] seen; logic to;
    run_op(2'b01, 4'd2, 16'h0001, -1, lat, sc, seen, bl, to);
    checks++; if (result !== 16'h0004) begin errors++; $display("FAIL b2b_first got %h want 0004", result); end
    start = 1'b1; op = 2'b01; amount = 4'd1; din = 16'h0003;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_done_edge got busy=%b done=%b want 0/0", busy, done); end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || sh_shift !== 2'b01) begin errors++; $display("FAIL b2b_accept got busy=%b sel=%b want 1/01", busy, sh_shift); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || result !== 16'h0006) begin errors++; $display("FAIL b2b_second got done=%b result=%h want 1/0006", done, result); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int lat, sc, bl; logic [1:0] seen; logic to;
    int done_seen;
    @(negedge clk);
    op = 2'b01; amount = 4'd8; din = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL arst_ctrl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (result !== 16'h0000 || sh_shift !== 2'b00 || sh_in !== 16'h0000) begin errors++; $display("FAIL arst_data got result=%h sel=%b in=%h want 0000/00/0000", result, sh_shift, sh_in); end
    done_seen = 0;
    repeat (2) begin @(posedge clk); #1; if (done === 1'b1) done_seen++; end
    @(negedge clk); reset_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done === 1'b1) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL arst_no_done got %0d pulses want 0", done_seen); end
    run_op(2'b10, 4'd4, 16'hF000, -1, lat, sc, seen, bl, to);
    checks++; if (result !== 16'h0F00 || lat != 4) begin errors++; $display("FAIL arst_recover got %h lat=%0d want 0F00 lat=4", result, lat); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_right();
    test_zero_amount();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
